// File: rtl/request_queue.sv
// Strict-FIFO request queue with EMPTY/ACTIVE/FULL occupancy tracking.
// Optional per-entry age counters and the out_age port are enabled by defining REQ_AGE_EN.
package request_queue_pkg;
  typedef enum logic [1:0] {
    NOP    = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    IFETCH = 2'd3
  } parsed_op_t;
endpackage

module request_queue
  import request_queue_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH   = 16,
  parameter int unsigned ADDRESS_WIDTH = 33
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  parsed_op_t                     in_op,
  input  logic [ADDRESS_WIDTH-1:0]       in_addr,
  output logic                           in_ready,
  output logic                           out_valid,
  output parsed_op_t                     out_op,
  output logic [ADDRESS_WIDTH-1:0]       out_addr,
  input  logic                           out_ready,
  output logic [$clog2(QUEUE_DEPTH):0]   count,
  output logic                           full,
`ifdef REQ_AGE_EN
  output logic                           empty,
  output logic [7:0]                     out_age
`else
  output logic                           empty
`endif
);

  localparam int unsigned PW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ACTIVE,
    OCC_FULL
  } occ_t;

  occ_t                     state_q, state_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PW-1:0]            rd_q, wr_q;
  parsed_op_t               mem_op   [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0] mem_addr [QUEUE_DEPTH];
  logic                     push, pop;

  assign full      = (state_q == OCC_FULL);
  assign empty     = (state_q == OCC_EMPTY);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign count     = count_q;

  assign push = in_valid && in_ready && (in_op != NOP);
  assign pop  = out_valid && out_ready;

  // Head is gated so a drained or freshly reset queue never exposes stale storage.
  assign out_op   = empty ? NOP : mem_op[rd_q];
  assign out_addr = empty ? '0  : mem_addr[rd_q];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (push) begin
          count_d = CW'(1);
          state_d = OCC_ACTIVE;
        end
      end
      OCC_ACTIVE: begin
        if (push && !pop) begin
          count_d = count_q + CW'(1);
          state_d = (count_q == CW'(QUEUE_DEPTH - 1)) ? OCC_FULL : OCC_ACTIVE;
        end else if (pop && !push) begin
          count_d = count_q - CW'(1);
          state_d = (count_q == CW'(1)) ? OCC_EMPTY : OCC_ACTIVE;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          count_d = count_q - CW'(1);
          state_d = OCC_ACTIVE;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OCC_EMPTY;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wr_q]   <= in_op;
      mem_addr[wr_q] <= in_addr;
    end
  end

`ifdef REQ_AGE_EN
  logic [7:0]             age [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] occupied;
  logic [PW-1:0]          offset;

  // An entry is occupied when its distance from the read pointer is below the count.
  always_comb begin
    occupied = '0;
    offset   = '0;
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      offset      = PW'(i) - rd_q;
      occupied[i] = ({1'b0, offset} < count_q);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
      if (push && (wr_q == PW'(i))) begin
        age[i] <= '0;
      end else if (occupied[i] && (age[i] != 8'hFF)) begin
        age[i] <= age[i] + 8'd1;
      end
    end
  end

  assign out_age = empty ? '0 : age[rd_q];
`endif

endmodule

// File: tb/tb_request_queue.sv
// Directed self-checking bench for request_queue; age checks run only when REQ_AGE_EN is defined.
module tb_request_queue;
  import request_queue_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 33;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  parsed_op_t              in_op;
  logic [AW-1:0]           in_addr;
  logic                    in_ready;
  logic                    out_valid;
  parsed_op_t              out_op;
  logic [AW-1:0]           out_addr;
  logic                    out_ready;
  logic [$clog2(DEPTH):0]  count;
  logic                    full;
  logic                    empty;
`ifdef REQ_AGE_EN
  logic [7:0]              out_age;
`endif

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;

  request_queue #(
    .QUEUE_DEPTH  (DEPTH),
    .ADDRESS_WIDTH(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_op    (in_op),
    .in_addr  (in_addr),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_op   (out_op),
    .out_addr (out_addr),
    .out_ready(out_ready),
    .count    (count),
    .full     (full),
`ifdef REQ_AGE_EN
    .empty    (empty),
    .out_age  (out_age)
`else
    .empty    (empty)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic parsed_op_t op_of(input int unsigned j);
    case (j % 3)
      0:       return READ;
      1:       return WRITE;
      default: return IFETCH;
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = NOP;
    in_addr   = '0;
    out_ready = 1'b0;
    tick();
    tick();

    check("rst_count", 64'(count), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_op", 64'(out_op), 64'(NOP));
    check("rst_out_addr", 64'(out_addr), 64'd0);

    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_op = READ; in_addr = 33'h0_1000_0040;
    tick();
    in_valid = 1'b0;
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_op", 64'(out_op), 64'(READ));
    check("first_addr", 64'(out_addr), 64'h0_1000_0040);
    check("first_count", 64'(count), 64'd1);

    out_ready = 1'b1;
    tick();
    check("pop_to_empty", 64'(empty), 64'd1);
    tick();
    out_ready = 1'b0;
    check("pop_on_empty_count", 64'(count), 64'd0);
    check("pop_on_empty_valid", 64'(out_valid), 64'd0);

    in_valid = 1'b1; in_op = NOP; in_addr = 33'h123;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("nop_empty", 64'(empty), 64'd1);
      check("nop_count", 64'(count), 64'd0);
    end

    in_op = WRITE;
    for (int i = 0; i < 16; i++) begin
      in_addr = 33'(32'h100 + i);
      tick();
      check("fill_count", 64'(count), 64'(i + 1));
    end
    check("fill_full", 64'(full), 64'd1);
    check("fill_in_ready", 64'(in_ready), 64'd0);

    in_addr = 33'h999;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_count", 64'(count), 64'd16);
    end

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("full_pop_only_count", 64'(count), 64'd15);
    check("full_pop_head", 64'(out_addr), 64'h101);
    tick();
    in_valid = 1'b0;
    check("held_accepted_count", 64'(count), 64'd16);
    check("held_accepted_full", 64'(full), 64'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_addr", 64'(out_addr), (i < 15) ? 64'(32'h101 + i) : 64'h999);
      check("drain_op", 64'(out_op), 64'(WRITE));
      tick();
    end
    check("drain_empty", 64'(empty), 64'd1);

    in_valid = 1'b1; in_op = READ; in_addr = 33'h200;
    tick();
    out_ready = 1'b0;
    check("empty_push_pop_count", 64'(count), 64'd1);
    check("empty_push_pop_head", 64'(out_addr), 64'h200);
    for (int i = 1; i < 5; i++) begin
      in_addr = 33'(32'h200 + i);
      tick();
    end
    check("preload_count", 64'(count), 64'd5);

    out_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      in_op   = op_of(j);
      in_addr = 33'(32'h300 + j);
      check("steady_head_addr", 64'(out_addr), (j < 5) ? 64'(32'h200 + j) : 64'(32'h300 + j - 5));
      check("steady_head_op", 64'(out_op), (j < 5) ? 64'(READ) : 64'(op_of(j - 5)));
      tick();
      check("steady_count", 64'(count), 64'd5);
    end
    in_valid = 1'b0;
    for (int j = 15; j < 20; j++) begin
      check("tail_addr", 64'(out_addr), 64'(32'h300 + j));
      check("tail_op", 64'(out_op), 64'(op_of(j)));
      tick();
    end
    out_ready = 1'b0;
    check("tail_empty", 64'(empty), 64'd1);

    in_valid = 1'b1; in_op = WRITE;
    for (int i = 0; i < 7; i++) begin
      in_addr = 33'(32'h400 + i);
      tick();
    end
    in_valid = 1'b0;
    check("prereset_count", 64'(count), 64'd7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_empty", 64'(empty), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_op", 64'(out_op), 64'(NOP));
    check("midrst_out_addr", 64'(out_addr), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);

    in_valid = 1'b1; in_op = IFETCH; in_addr = 33'h1_FFFF_FFC0;
    tick();
    in_valid = 1'b0;
    check("postrst_op", 64'(out_op), 64'(IFETCH));
    check("postrst_addr", 64'(out_addr), 64'h1_FFFF_FFC0);
    check("postrst_count", 64'(count), 64'd1);

`ifdef REQ_AGE_EN
    check("age_start", 64'(out_age), 64'd0);
    for (int k = 1; k <= 300; k++) begin
      tick();
      check("age_ramp", 64'(out_age), (k < 255) ? 64'(k) : 64'd255);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("age_empty", 64'(out_age), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/request_queue.md
REQUEST_QUEUE -- requirements
Module: request_queue

Interface
REQ-001 The block SHALL have parameter QUEUE_DEPTH, default 16, number of queue entries; power of two, minimum 2.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 33, width of request address.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  producer presents a request this cycle.
REQ-006 The block SHALL have port in_op  input  parsed_op_t  request opcode (READ, WRITE, IFETCH, NOP).
REQ-007 The block SHALL have port in_addr  input  ADDRESS_WIDTH  request address.
REQ-008 The block SHALL have port in_ready  output  1  queue can accept a request this cycle.
REQ-009 The block SHALL have port out_valid  output  1  head entry is valid.
REQ-010 The block SHALL have port out_op  output  parsed_op_t  head entry opcode.
REQ-011 The block SHALL have port out_addr  output  ADDRESS_WIDTH  head entry address.
REQ-012 The block SHALL have port out_ready  input  1  consumer takes the head entry this cycle.
REQ-013 The block SHALL have port count  output  $clog2(QUEUE_DEPTH)+1  number of occupied entries.
REQ-014 The block SHALL have ports full and empty  output  1 each  occupancy flags.
REQ-015 The block SHALL have port out_age  output  8  cycles the head entry has spent queued (present only with REQ_AGE_EN).

Function
REQ-016 The queue SHALL be strict FIFO; entries leave in arrival order.
REQ-017 Push SHALL occur when in_valid && in_ready && in_op != NOP; a NOP SHALL be discarded without changing any state.
REQ-018 Pop SHALL occur when out_valid && out_ready; out_ready with out_valid low SHALL have no effect.
REQ-019 in_ready SHALL equal !full; a producer seeing in_ready low SHALL hold its request, and the queue SHALL NOT drop it.
REQ-020 out_valid SHALL equal !empty; out_op/out_addr SHALL reflect the head entry combinationally from stored state.
REQ-021 Latency SHALL be one cycle: a request pushed at edge N is visible on out_* after edge N; no same-cycle bypass when empty.
REQ-022 Occupancy state SHALL be EMPTY (count 0), ACTIVE (0<count<QUEUE_DEPTH) or FULL (count QUEUE_DEPTH); transitions only by ±1 per cycle.
REQ-023 Simultaneous push and pop in ACTIVE SHALL leave count unchanged and advance both pointers.
REQ-024 Simultaneous push and pop SHALL be impossible in FULL (in_ready low) and in EMPTY (out_valid low); only the legal operation takes effect.
REQ-025 Read and write pointers SHALL be $clog2(QUEUE_DEPTH) bits and wrap from QUEUE_DEPTH-1 to 0.
REQ-026 full SHALL assert exactly when count == QUEUE_DEPTH; empty exactly when count == 0.

Reset
REQ-027 While rst_n is low at a rising edge, pointers and count SHALL clear to 0, so empty=1, full=0, in_ready=1, out_valid=0.
REQ-028 Reset mid-operation SHALL discard all queued entries; out_op SHALL read NOP and out_addr 0 while empty.
REQ-029 Entry storage contents need not be cleared by reset.

Configuration
REQ-030 With macro REQ_AGE_EN defined, each entry SHALL hold an 8-bit age set to 0 on push and incremented every cycle while occupied, saturating at 255; out_age SHALL show the head age (0 when empty).
REQ-031 Without REQ_AGE_EN, no age counters SHALL exist and port out_age SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then push READ 0x0_1000_0040 at cycle 2 -> out_valid=1, out_op=READ, out_addr=0x0_1000_0040 after cycle-2 edge, count=1.
REQ-033 Push 16 distinct WRITE requests with out_ready=0 -> full=1, in_ready=0 after 16th; 17th request held by producer, count stays 16.
REQ-034 From count=5, push and pop in same cycle for 20 cycles -> count stays 5, pops return entries in push order across pointer wrap.
REQ-035 Present in_valid=1 with in_op=NOP for 3 cycles on empty queue -> empty stays 1, count 0.
REQ-036 With REQ_AGE_EN, push IFETCH 0x1_FFFF_FFC0 and hold out_ready=0 for 300 cycles -> out_age rises 0..255 and holds 255.
REQ-037 Fill to count=7, assert rst_n=0 for one edge -> count=0, empty=1, out_valid=0 next cycle; next push appears at head.
